haar_dwt_ml: RTL and testbench
==============================

Name: haar_dwt_ml

Overview:
Multi-level, streaming Haar DWT engine for the dwt/ signal chain. It buffers one frame of 2^LOG2_LEN signed samples over a valid/ready input stream, then computes 1..LOG2_LEN decomposition levels in place, one pair per cycle. It streams all coefficients out in Mallat order with level/type tags under output backpressure. It succeeds the single-level haar_dwt with a runtime level count, handshaked I/O and signed arithmetic.

Parameters:
- DATA_WIDTH, 8, signed sample and coefficient width.
- LOG2_LEN, 3, log2 of frame length; N = 2^LOG2_LEN, max levels = LOG2_LEN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  DATA_WIDTH  signed input sample.
- in_valid  in  1  din valid.
- in_ready  out  1  block accepts din; transfer occurs when in_valid && in_ready.
- cfg_levels  in  4  requested decomposition levels; sampled with the first sample of a frame.
- dout  out  DATA_WIDTH  signed coefficient.
- out_valid  out  1  dout valid.
- out_ready  in  1  sink accepts dout.
- out_is_detail  out  1  0 = approximation, 1 = detail.
- out_level  out  4  decomposition level of the coefficient, 1..L.
- out_last  out  1  final coefficient of the frame.
- done  out  1  one-cycle pulse on the cycle after the final beat is accepted.

Behaviour:
- Reset (async, any state): state = LOAD, counters = 0, all outputs 0 (in_ready 0 while rst is high, 1 on the first cycle after release). Buffers need not be cleared. A frame in progress is discarded with no partial output.
- States: LOAD, COMPUTE, OUTPUT.
- LOAD: in_ready = 1. Each accepted sample goes to work[k], k = 0..N-1. On k = 0, latch L = clamp(cfg_levels): 0 → 1, > LOG2_LEN → LOG2_LEN. After the Nth accept, go to COMPUTE and drop in_ready on the next cycle.
- COMPUTE: in_ready = 0. Level l = 1..L runs with len = N >> (l-1). For pair i = 0..len/2-1, one pair per cycle:
  - x0 = work[2i], x1 = work[2i+1].
  - work[i] <= (x0 + x1) >>> 1.
  - det[len/2 + i] <= (x0 - x1) >>> 1.
  - Sum and difference are computed at DATA_WIDTH+1 bits, arithmetic right shift (floor), truncated to DATA_WIDTH. The result always fits, so there is no saturation.
  - Pairs run in ascending i; the in-place write to work[i] never clobbers unread data.
- COMPUTE length: C = N - (N >> L) cycles. Go to OUTPUT after the last pair.
- out_valid first asserts C+1 edges after the edge that accepted the last sample.
- OUTPUT: N beats, index j = 0..N-1.
  - j < N>>L: dout = work[j], out_is_detail = 0, out_level = L.
  - Otherwise: dout = det[j], out_is_detail = 1, out_level = l such that N>>l <= j < N>>(l-1).
  - out_last = 1 on j = N-1.
  - Beat advances only when out_valid && out_ready. While out_valid && !out_ready, dout and all tags hold stable.
- After the final beat is accepted: out_valid = 0, done pulses for one cycle, state returns to LOAD, and in_ready = 1 on that same cycle.
- in_valid is ignored outside LOAD. out_ready is ignored outside OUTPUT.
- Throughput with continuous ready: N + C + N cycles per frame plus 1–2 cycles of state-change overhead.

Test Plan:
- N=8, L=1, din 0..7, out_ready = 1 → dout 0,2,4,6,-1,-1,-1,-1; is_detail 0,0,0,0,1,1,1,1; level all 1; out_last on the 8th beat; done 1 cycle later; out_valid rises 5 edges after the last accept.
- N=8, L=3, din 0..7 → dout 3,-2,-1,-1,-1,-1,-1,-1; level 3,3,2,2,1,1,1,1; is_detail 0,1,1,1,1,1,1,1; out_valid rises 8 edges after the last accept.
- Signed extremes, L=1, din pair (-128, 127) repeated → a = -1, d = -128 for every pair; no wrap.
- cfg_levels = 7 → identical to L=3. cfg_levels = 0 → identical to L=1. cfg_levels changed mid-frame → no effect on the current frame.
- out_ready random toggling (about 50%) across the L=3 frame → same sequence as scenario 2; dout and tags stable on every stalled cycle; no beat dropped or duplicated. Back-to-back second frame streams correctly after done.
- rst asserted mid-COMPUTE and mid-OUTPUT → outputs 0 immediately (async); after release in_ready = 1; a new frame 0..7 with L=1 yields exactly scenario 1.

Source files
------------

// File: rtl/haar_dwt_ml.sv
// Multi-level streaming Haar DWT engine.
// Buffers one frame of N = 2^LOG2_LEN signed samples and computes 1..LOG2_LEN
// levels in place (one pair per cycle). It then streams the coefficients in
// Mallat order with level/type tags under output backpressure.
module haar_dwt_ml #(
    parameter int DATA_WIDTH = 8,
    parameter int LOG2_LEN   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            cfg_levels,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_is_detail,
    output logic [3:0]            out_level,
    output logic                  out_last,
    output logic                  done
);

    localparam int unsigned N  = 1 << LOG2_LEN;
    localparam int          IW = LOG2_LEN;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        OUTPUT
    } state_t;

    state_t state, state_next;

    // Frame buffers: work holds samples, then approximations in place;
    // det holds detail coefficients at their Mallat positions.
    logic [DATA_WIDTH-1:0] work [N];
    logic [DATA_WIDTH-1:0] det  [N];

    logic [IW-1:0] load_cnt;
    logic [IW-1:0] pair_idx;
    logic [IW-1:0] out_idx;
    logic [3:0]    levels;
    logic [3:0]    lvl_cnt;
    logic          primed;
    logic          done_r;

    logic                         in_fire;
    logic                         out_fire;
    logic                         last_load;
    logic                         last_pair;
    logic                         last_level;
    logic                         last_beat;
    logic [IW:0]                  half;
    logic [IW:0]                  n_approx;
    logic [IW-1:0]                idx0;
    logic [IW-1:0]                idx1;
    logic [IW-1:0]                idx_det;
    logic signed [DATA_WIDTH-1:0] x0;
    logic signed [DATA_WIDTH-1:0] x1;
    logic signed [DATA_WIDTH:0]   sum_c;
    logic signed [DATA_WIDTH:0]   diff_c;
    logic signed [DATA_WIDTH-1:0] approx_c;
    logic signed [DATA_WIDTH-1:0] detail_c;
    logic [3:0]                   cfg_clamped;
    logic [3:0]                   det_level;

    assign in_fire    = (state == LOAD) && in_valid;
    assign out_fire   = out_valid && out_ready;
    assign last_load  = (load_cnt == IW'(N - 1));
    assign half       = (IW + 1)'(N >> lvl_cnt);
    assign n_approx   = (IW + 1)'(N >> levels);
    assign last_pair  = (pair_idx == IW'(half - 1'b1));
    assign last_level = (lvl_cnt == levels);
    assign last_beat  = (out_idx == IW'(N - 1));
    assign done       = done_r;

    // Pair arithmetic: sum/difference at DATA_WIDTH+1 bits, floor halving.
    always_comb begin
        idx0     = IW'({pair_idx, 1'b0});
        idx1     = idx0 | IW'(1);
        idx_det  = IW'(half) + pair_idx;
        x0       = work[idx0];
        x1       = work[idx1];
        sum_c    = {x0[DATA_WIDTH-1], x0} + {x1[DATA_WIDTH-1], x1};
        diff_c   = {x0[DATA_WIDTH-1], x0} - {x1[DATA_WIDTH-1], x1};
        approx_c = DATA_WIDTH'(sum_c >>> 1);
        detail_c = DATA_WIDTH'(diff_c >>> 1);
    end

    // Clamp requested level count into 1..LOG2_LEN.
    always_comb begin
        if (cfg_levels == '0)
            cfg_clamped = 4'd1;
        else if (cfg_levels > 4'(LOG2_LEN))
            cfg_clamped = 4'(LOG2_LEN);
        else
            cfg_clamped = cfg_levels;
    end

    // Level of a detail coefficient: N>>l <= j < N>>(l-1).
    always_comb begin
        det_level = '0;
        for (int unsigned l = 1; l <= LOG2_LEN; l++) begin
            if ((32'(out_idx) >= (N >> l)) && (32'(out_idx) < (N >> (l - 1))))
                det_level = 4'(l);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= LOAD;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (in_fire && last_load) state_next = COMPUTE;
            COMPUTE: if (last_pair && last_level) state_next = OUTPUT;
            OUTPUT:  if (out_fire && last_beat) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Output decode. out_valid waits one cycle after entering OUTPUT (primed).
    always_comb begin
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        dout          = '0;
        out_is_detail = 1'b0;
        out_level     = '0;
        out_last      = 1'b0;
        case (state)
            LOAD: in_ready = !rst;
            OUTPUT: begin
                if (primed) begin
                    out_valid = 1'b1;
                    out_last  = last_beat;
                    if ({1'b0, out_idx} < n_approx) begin
                        dout      = work[out_idx];
                        out_level = levels;
                    end else begin
                        dout          = det[out_idx];
                        out_is_detail = 1'b1;
                        out_level     = det_level;
                    end
                end
            end
            default: ;
        endcase
    end

    // Control counters, latched level count, output priming and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt <= '0;
            pair_idx <= '0;
            lvl_cnt  <= '0;
            out_idx  <= '0;
            levels   <= '0;
            primed   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        if (load_cnt == '0)
                            levels <= cfg_clamped;
                        load_cnt <= load_cnt + 1'b1;
                        if (last_load) begin
                            pair_idx <= '0;
                            lvl_cnt  <= 4'd1;
                        end
                    end
                end
                COMPUTE: begin
                    if (last_pair) begin
                        pair_idx <= '0;
                        lvl_cnt  <= lvl_cnt + 1'b1;
                        out_idx  <= '0;
                    end else begin
                        pair_idx <= pair_idx + 1'b1;
                    end
                end
                OUTPUT: begin
                    primed <= 1'b1;
                    if (out_fire) begin
                        out_idx <= out_idx + 1'b1;
                        if (last_beat) begin
                            primed <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame buffer writes; in-place work[i] never overtakes reads of 2i, 2i+1.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            work[load_cnt] <= din;
        end else if (state == COMPUTE) begin
            work[pair_idx] <= approx_c;
            det[idx_det]   <= detail_c;
        end
    end

endmodule

// File: tb/tb_haar_dwt_ml.sv
// Directed self-checking bench for haar_dwt_ml (N = 8).
module tb_haar_dwt_ml;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] din;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        cfg_levels;
    logic signed [7:0] dout;
    logic              out_valid;
    logic              out_ready;
    logic              out_is_detail;
    logic [3:0]        out_level;
    logic              out_last;
    logic              done;

    int checks   = 0;
    int failures = 0;

    int stim    [8];
    int exp_d   [8];
    int exp_det [8];
    int exp_lvl [8];

    haar_dwt_ml #(
        .DATA_WIDTH(8),
        .LOG2_LEN  (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cfg_levels   (cfg_levels),
        .dout         (dout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_is_detail(out_is_detail),
        .out_level    (out_level),
        .out_last     (out_last),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_s1();
        stim    = '{0, 1, 2, 3, 4, 5, 6, 7};
        exp_d   = '{0, 2, 4, 6, -1, -1, -1, -1};
        exp_det = '{0, 0, 0, 0, 1, 1, 1, 1};
        exp_lvl = '{1, 1, 1, 1, 1, 1, 1, 1};
    endtask

    task automatic set_s2();
        stim    = '{0, 1, 2, 3, 4, 5, 6, 7};
        exp_d   = '{3, -2, -1, -1, -1, -1, -1, -1};
        exp_det = '{0, 1, 1, 1, 1, 1, 1, 1};
        exp_lvl = '{3, 3, 2, 2, 1, 1, 1, 1};
    endtask

    task automatic set_ext();
        stim    = '{-128, 127, -128, 127, -128, 127, -128, 127};
        exp_d   = '{-1, -1, -1, -1, -128, -128, -128, -128};
        exp_det = '{0, 0, 0, 0, 1, 1, 1, 1};
        exp_lvl = '{1, 1, 1, 1, 1, 1, 1, 1};
    endtask

    // Push one frame; cfg_first goes with sample 0, cfg_rest with the others.
    task automatic load_frame(input logic [3:0] cfg_first, input logic [3:0] cfg_rest);
        int guard;
        for (int k = 0; k < 8; k++) begin
            din        = 8'(stim[k]);
            in_valid   = 1'b1;
            cfg_levels = (k == 0) ? cfg_first : cfg_rest;
            guard      = 0;
            while (!in_ready && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 50) check("in_ready_timeout", guard, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        din      = '0;
        check("in_ready_drop", in_ready, 0);
    endtask

    task automatic wait_valid(input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
    endtask

    task automatic check_beat(input string pfx, input int j);
        check($sformatf("%s_valid[%0d]", pfx, j), out_valid, 1);
        check($sformatf("%s_dout[%0d]", pfx, j), int'(dout), exp_d[j]);
        check($sformatf("%s_det[%0d]", pfx, j), out_is_detail, exp_det[j]);
        check($sformatf("%s_lvl[%0d]", pfx, j), out_level, exp_lvl[j]);
        check($sformatf("%s_last[%0d]", pfx, j), out_last, (j == 7) ? 1 : 0);
    endtask

    // Drain one frame; rand_ready toggles out_ready, stalled cycles are checked too.
    task automatic recv_frame(input bit rand_ready);
        int j = 0;
        int guard = 0;
        while (j < 8 && guard < 400) begin
            guard++;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            check_beat("beat", j);
            @(posedge clk); #1;
            if (out_ready) j++;
            else check_beat("stall", j);
        end
        check("rx_beats", j, 8);
        check("done_pulse", done, 1);
        check("valid_after", out_valid, 0);
        check("in_ready_after", in_ready, 1);
        @(posedge clk); #1;
        check("done_low", done, 0);
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_out_valid"}, out_valid, 0);
        check({pfx, "_dout"}, int'(dout), 0);
        check({pfx, "_is_detail"}, out_is_detail, 0);
        check({pfx, "_level"}, out_level, 0);
        check({pfx, "_last"}, out_last, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_in_ready"}, in_ready, 0);
    endtask

    initial begin
        rst        = 1'b1;
        din        = '0;
        in_valid   = 1'b0;
        cfg_levels = '0;
        out_ready  = 1'b0;
        #1;
        check_idle_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("in_ready_release", in_ready, 1);
        @(posedge clk); #1;

        // L=1, ascending ramp
        set_s1();
        load_frame(4'd1, 4'd1);
        wait_valid(5);
        recv_frame(1'b0);

        // L=3, ascending ramp
        set_s2();
        load_frame(4'd3, 4'd3);
        wait_valid(8);
        recv_frame(1'b0);

        // signed extremes, L=1
        set_ext();
        load_frame(4'd1, 4'd1);
        wait_valid(5);
        recv_frame(1'b0);

        // clamp high: 7 behaves as 3
        set_s2();
        load_frame(4'd7, 4'd7);
        wait_valid(8);
        recv_frame(1'b0);

        // clamp low: 0 behaves as 1
        set_s1();
        load_frame(4'd0, 4'd0);
        wait_valid(5);
        recv_frame(1'b0);

        // cfg_levels changed after first sample has no effect
        set_s2();
        load_frame(4'd3, 4'd1);
        wait_valid(8);
        recv_frame(1'b0);

        // random backpressure on L=3, then back-to-back L=1 frame
        set_s2();
        load_frame(4'd3, 4'd3);
        wait_valid(8);
        recv_frame(1'b1);
        out_ready = 1'b1;
        set_s1();
        load_frame(4'd1, 4'd1);
        wait_valid(5);
        recv_frame(1'b0);

        // reset during COMPUTE
        set_s2();
        load_frame(4'd3, 4'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1 check_idle_outputs("rst_compute");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("rst_compute_release", in_ready, 1);
        @(posedge clk); #1;

        // reset during OUTPUT after two accepted beats
        set_s2();
        load_frame(4'd3, 4'd3);
        wait_valid(8);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_dout", int'(dout), exp_d[2]);
        #2 rst = 1'b1;
        #1 check_idle_outputs("rst_output");
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("rst_output_release", in_ready, 1);
        check("rst_output_valid", out_valid, 0);
        @(posedge clk); #1;

        // fresh frame after reset reproduces the L=1 result
        set_s1();
        load_frame(4'd1, 4'd1);
        wait_valid(5);
        recv_frame(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
